// File: rtl/posit_div_result_queue_if.sv
// ============================================================================
// posit_div_result_queue_if : result push and consumer pop handshake bundle
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface posit_div_result_queue_if #(
  parameter int N  = 32,
  parameter int TW = 4
);
  logic          in_valid;
  logic [N-1:0]  in_data;
  logic          in_inf;
  logic          in_zero;
  logic [TW-1:0] in_tag;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic [TW-1:0] out_tag;
  logic [1:0]    out_flags;

  modport slave (
    input  in_valid, in_data, in_inf, in_zero, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_flags
  );

  modport master (
    output in_valid, in_data, in_inf, in_zero, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_flags
  );
endinterface

`default_nettype wire

// File: rtl/posit_div_result_queue.sv
// ============================================================================
// posit_div_result_queue : DEPTH-entry result FIFO behind the posit divider
// Optional statistics counters: define POSIT_DIV_RESULT_QUEUE_STATS_EN
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module posit_div_result_queue #(
  parameter int N     = 32,
  parameter int DEPTH = 4,
  parameter int TW    = 4,
  parameter int CW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  posit_div_result_queue_if.slave  bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_err,
  input  logic                     err_clr
`ifdef POSIT_DIV_RESULT_QUEUE_STATS_EN
  ,
  output logic [CW-1:0]            nar_cnt,
  output logic [CW-1:0]            zero_cnt
`endif
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int EW   = N + TW + 2;
  localparam logic [CNTW-1:0] C_FULL = CNTW'(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || CW < 1) begin : g_bad_param
    $error("posit_div_result_queue: illegal DEPTH or CW");
  end

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  logic [EW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic            r_ovf_err;

  state_t          w_state;
  logic            w_push;
  logic            w_pop;
  logic            w_ovf;
  logic [CNTW-1:0] w_count_nxt;
  logic [N-1:0]    w_wdata;
  logic [1:0]      w_wflags;
  logic [EW-1:0]   w_head;

  // Occupancy is the state; the enum only names its three regions.
  always_comb begin
    w_state     = S_PARTIAL;
    w_count_nxt = r_count;
    if (r_count == '0) begin
      w_state = S_EMPTY;
    end else if (r_count == C_FULL) begin
      w_state = S_FULL;
    end
    w_push = bus.in_valid && (w_state != S_FULL);
    w_pop  = bus.out_ready && (w_state != S_EMPTY);
    w_ovf  = bus.in_valid && (w_state == S_FULL);
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNTW'(1);
      2'b01:   w_count_nxt = r_count - CNTW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // NaR takes priority over zero when the divider flags both.
  always_comb begin
    w_wdata  = bus.in_data;
    w_wflags = 2'b00;
    if (bus.in_inf) begin
      w_wdata  = {1'b1, {(N-1){1'b0}}};
      w_wflags = 2'b10;
    end else if (bus.in_zero) begin
      w_wdata  = '0;
      w_wflags = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= {w_wflags, bus.in_tag, w_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_ovf_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      if (w_ovf) begin
        r_ovf_err <= 1'b1;
      end else if (err_clr) begin
        r_ovf_err <= 1'b0;
      end
    end
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign bus.in_ready  = (w_state != S_FULL);
  assign bus.out_valid = (w_state != S_EMPTY);
  assign bus.out_data  = w_head[N-1:0];
  assign bus.out_tag   = w_head[N +: TW];
  assign bus.out_flags = w_head[EW-1 -: 2];
  assign count         = r_count;
  assign ovf_err       = r_ovf_err;

`ifdef POSIT_DIV_RESULT_QUEUE_STATS_EN
  logic [CW-1:0] r_nar_cnt;
  logic [CW-1:0] r_zero_cnt;
  logic          w_cnt_nar;
  logic          w_cnt_zero;

  assign w_cnt_nar  = w_push && (w_wflags == 2'b10);
  assign w_cnt_zero = w_push && (w_wflags == 2'b01);

  // A clear coinciding with a counted push leaves that push counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nar_cnt  <= '0;
      r_zero_cnt <= '0;
    end else if (err_clr) begin
      r_nar_cnt  <= CW'(w_cnt_nar);
      r_zero_cnt <= CW'(w_cnt_zero);
    end else begin
      if (w_cnt_nar && (r_nar_cnt != '1)) begin
        r_nar_cnt <= r_nar_cnt + CW'(1);
      end
      if (w_cnt_zero && (r_zero_cnt != '1)) begin
        r_zero_cnt <= r_zero_cnt + CW'(1);
      end
    end
  end

  assign nar_cnt  = r_nar_cnt;
  assign zero_cnt = r_zero_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_posit_div_result_queue.sv
// ============================================================================
// tb_posit_div_result_queue : queue-model scoreboard plus directed literals
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_posit_div_result_queue;
  localparam int N     = 32;
  localparam int DEPTH = 4;
  localparam int TW    = 4;
  localparam int CW    = 16;
  localparam int CNTW  = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_clr = 1'b0;
  logic [CNTW-1:0] count;
  logic ovf_err;
  logic chk_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
`ifdef POSIT_DIV_RESULT_QUEUE_STATS_EN
  logic [CW-1:0] nar_cnt;
  logic [CW-1:0] zero_cnt;
`endif

  posit_div_result_queue_if #(.N(N), .TW(TW)) bus ();

  posit_div_result_queue #(.N(N), .DEPTH(DEPTH), .TW(TW), .CW(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .count   (count),
    .ovf_err (ovf_err),
    .err_clr (err_clr)
`ifdef POSIT_DIV_RESULT_QUEUE_STATS_EN
    ,
    .nar_cnt (nar_cnt),
    .zero_cnt(zero_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  d;
    logic [TW-1:0] t;
    logic [1:0]    f;
  } ent_t;

  ent_t q[$];
  logic m_ovf = 1'b0;
  int   m_nar = 0;
  int   m_zero = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: FIFO of canonicalised results.
  always @(posedge clk) begin
    ent_t e;
    bit full, push, pop;
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_nar = 0;
      m_zero = 0;
    end else begin
      full = (q.size() == DEPTH);
      push = bus.in_valid && !full;
      pop  = bus.out_ready && (q.size() > 0);
      e.t  = bus.in_tag;
      if (bus.in_inf) begin
        e.d = 32'h8000_0000; e.f = 2'b10;
      end else if (bus.in_zero) begin
        e.d = 32'h0; e.f = 2'b01;
      end else begin
        e.d = bus.in_data; e.f = 2'b00;
      end
      if (pop) void'(q.pop_front());
      if (push) q.push_back(e);
      if (bus.in_valid && full) m_ovf = 1'b1;
      else if (err_clr) m_ovf = 1'b0;
      if (err_clr) begin
        m_nar  = (push && e.f == 2'b10) ? 1 : 0;
        m_zero = (push && e.f == 2'b01) ? 1 : 0;
      end else begin
        if (push && e.f == 2'b10 && m_nar < (1 << CW) - 1) m_nar++;
        if (push && e.f == 2'b01 && m_zero < (1 << CW) - 1) m_zero++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 64'(count), 64'(q.size()));
      chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
      chk("in_ready", 64'(bus.in_ready), 64'(q.size() < DEPTH));
      chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
      if (q.size() > 0) begin
        chk("out_data", 64'(bus.out_data), 64'(q[0].d));
        chk("out_tag", 64'(bus.out_tag), 64'(q[0].t));
        chk("out_flags", 64'(bus.out_flags), 64'(q[0].f));
      end
`ifdef POSIT_DIV_RESULT_QUEUE_STATS_EN
      chk("nar_cnt", 64'(nar_cnt), 64'(m_nar));
      chk("zero_cnt", 64'(zero_cnt), 64'(m_zero));
`endif
    end
  end

  task automatic cyc(input logic v, input logic [N-1:0] d, input logic inf, input logic zero,
                     input logic [TW-1:0] t, input logic ordy, input logic clr, input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_inf    = inf;
    bus.in_zero   = zero;
    bus.in_tag    = t;
    bus.out_ready = ordy;
    err_clr       = clr;
    rst           = r;
    @(negedge clk);
  endtask

  task automatic push(input logic [N-1:0] d, input logic [TW-1:0] t);
    cyc(1'b1, d, 1'b0, 1'b0, t, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop();
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 2 * DEPTH && bus.out_valid; k++) pop();
    chk("drained", 64'(bus.out_valid), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    chk("rst count", 64'(count), 64'(0));
    chk("rst in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst ovf", 64'(ovf_err), 64'(0));

    // single result
    push(32'h4000_0000, 4'd3);
    chk("single valid", 64'(bus.out_valid), 64'(1));
    chk("single data", 64'(bus.out_data), 64'h4000_0000);
    chk("single tag", 64'(bus.out_tag), 64'(3));
    chk("single flags", 64'(bus.out_flags), 64'(0));
    chk("single count", 64'(count), 64'(1));
    pop();
    chk("single empty", 64'(bus.out_valid), 64'(0));

    // fill, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) push(32'h1000_0000 + 32'(i), TW'(i));
    chk("full count", 64'(count), 64'(4));
    chk("full in_ready", 64'(bus.in_ready), 64'(0));
    push(32'hdead_beef, 4'd9);
    chk("ovf set", 64'(ovf_err), 64'(1));
    chk("ovf count", 64'(count), 64'(4));
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain tag", 64'(bus.out_tag), 64'(i));
      pop();
    end
    chk("drain empty", 64'(count), 64'(0));

    // steady push+pop at count=2
    push(32'h2000_0000, 4'd0);
    push(32'h2000_0001, 4'd1);
    for (int i = 2; i < 12; i++) begin
      cyc(1'b1, 32'h2000_0000 + 32'(i), 1'b0, 1'b0, TW'(i), 1'b1, 1'b0, 1'b0);
      chk("steady count", 64'(count), 64'(2));
    end
    push(32'h3000_0000, 4'd12);
    push(32'h3000_0001, 4'd13);
    chk("refill count", 64'(count), 64'(4));
    cyc(1'b1, 32'h3000_0002, 1'b0, 1'b0, 4'd14, 1'b1, 1'b0, 1'b0);
    chk("full pushpop count", 64'(count), 64'(3));
    drain();

    // exceptions
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("clr ovf", 64'(ovf_err), 64'(0));
    cyc(1'b1, 32'h1234_5678, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h1234_5678, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h1234_5678, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
    chk("nar data", 64'(bus.out_data), 64'h8000_0000);
    chk("nar flags", 64'(bus.out_flags), 64'(2));
    pop();
    chk("zero data", 64'(bus.out_data), 64'(0));
    chk("zero flags", 64'(bus.out_flags), 64'(1));
    pop();
    chk("both flags", 64'(bus.out_flags), 64'(2));
`ifdef POSIT_DIV_RESULT_QUEUE_STATS_EN
    chk("nar_cnt lit", 64'(nar_cnt), 64'(2));
    chk("zero_cnt lit", 64'(zero_cnt), 64'(1));
`endif
    pop();

    // reset mid-operation with ovf set
    for (int i = 0; i < DEPTH + 1; i++) push(32'h5000_0000 + 32'(i), TW'(i));
    pop();
    chk("pre-rst count", 64'(count), 64'(3));
    chk("pre-rst ovf", 64'(ovf_err), 64'(1));
    cyc(1'b1, 32'h5555_5555, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0, 1'b1);
    chk("mid-rst count", 64'(count), 64'(0));
    chk("mid-rst valid", 64'(bus.out_valid), 64'(0));
    chk("mid-rst in_ready", 64'(bus.in_ready), 64'(1));
    chk("mid-rst ovf", 64'(ovf_err), 64'(0));

    // wrap-around with random pops
    for (int i = 0; i < 3 * DEPTH; i++) begin
      cyc(1'b1, $urandom, 1'(($urandom & 7) == 0), 1'(($urandom & 7) == 1), TW'(i),
          1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    drain();

    // clear coincident with overflow, then lone clear
    for (int i = 0; i < DEPTH; i++) push(32'h6000_0000 + 32'(i), TW'(i));
    cyc(1'b1, 32'h6000_00ff, 1'b0, 1'b0, 4'd15, 1'b0, 1'b1, 1'b0);
    chk("clr+ovf", 64'(ovf_err), 64'(1));
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("lone clr", 64'(ovf_err), 64'(0));
    drain();
    cyc(1'b1, 32'h0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1, 1'b0);
`ifdef POSIT_DIV_RESULT_QUEUE_STATS_EN
    chk("clr+push nar_cnt", 64'(nar_cnt), 64'(1));
`endif
    drain();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
